// File: rtl/btn_pkg.sv
// Shared definitions for the push-button request front end: button count,
// FSM state type and the highest-index one-hot selector.
package btn_pkg;

    localparam int unsigned NUM_BTN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } btn_state_t;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [NUM_BTN-1:0] onehot_hi(input logic [NUM_BTN-1:0] v);
        logic [NUM_BTN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button lane: 2-FF synchroniser, plus a restart-on-glitch debounce
// counter when BTN_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic db_o
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = btn_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             db_d, db_q;

    // Any cycle where the synchronised level matches the accepted one restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o = db_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{DEBOUNCE_CYCLES, CNT_W};
    assign db_o       = s2_q;
`endif

endmodule

// File: rtl/btn_onehot_latch.sv
// Button front end for the 4-to-2 encoder: press edges become a held one-hot
// request with valid/ack handshake. Debounce is enabled by BTN_DEBOUNCE_EN.
module btn_onehot_latch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               ack,
    output logic [NUM_BTN-1:0] y,
    output logic               valid,
    output logic               overrun
);

    logic [NUM_BTN-1:0] db;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn[i]),
            .db_o  (db[i])
        );
    end

    btn_state_t         state_d, state_q;
    logic [NUM_BTN-1:0] y_d, y_q;
    logic               overrun_d, overrun_q;
    logic [NUM_BTN-1:0] db_prev_d, db_prev_q;

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] win;
    logic               multi;

    always_comb begin
        rise      = db & ~db_prev_q;
        win       = onehot_hi(rise);
        multi     = |(rise & ~win);
        db_prev_d = db;

        state_d   = state_q;
        y_d       = y_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (|rise) begin
                    y_d       = win;
                    state_d   = HOLD;
                    overrun_d = overrun_q | multi;
                end
            end
            HOLD: begin
                if (ack) begin
                    if (|rise) begin
                        y_d       = win;
                        overrun_d = overrun_q | multi;
                    end else begin
                        y_d     = '0;
                        state_d = IDLE;
                    end
                end else if (|rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                y_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            overrun_q <= 1'b0;
            db_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            overrun_q <= overrun_d;
            db_prev_q <= db_prev_d;
        end
    end

    assign y       = y_q;
    assign valid   = (state_q == HOLD);
    assign overrun = overrun_q;

endmodule
